// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Write-back end of the pipeline. Takes the MEM/WB pipeline register outputs
// and commits them to the 31-entry general register file and the HI/LO pair.
// It also serves the two combinational read ports used by the decode stage.
//
// Same-cycle write-to-read bypass (BYPASS=1) returns the value being written
// this cycle. Decode therefore needs no separate WB forwarding path.
//
// Parameters:
//   BYPASS      1: bypass wb_* onto the GPR read ports and onto hi/lo.
//               0: read ports and hi/lo return stored values only.
//
// Ports:
//   clk         single clock; all state updates on the rising edge
//   reset       asynchronous, active-high; clears all state
//   wb_en       GPR write enable
//   wb_addr     GPR destination index (index 0 is discarded)
//   wb_data     GPR write data
//   wb_hilo_en  HI/LO write enable (HI and LO are always written together)
//   wb_hi       HI write data
//   wb_lo       LO write data
//   rd1_en      read port 1 enable
//   rd1_addr    read port 1 index
//   rd1_data    read port 1 data, combinational
//   rd2_en      read port 2 enable
//   rd2_addr    read port 2 index
//   rd2_data    read port 2 data, combinational
//   hi          current HI, combinational
//   lo          current LO, combinational
//
// Read-port contract: the outputs have no valid/ready handshake. They are
// pure functions of the current inputs and the stored state, valid whenever
// the inputs are stable.
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter bit BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        wb_hilo_en,
   input  logic [31:0] wb_hi,
   input  logic [31:0] wb_lo,
   input  logic        rd1_en,
   input  logic [4:0]  rd1_addr,
   output logic [31:0] rd1_data,
   input  logic        rd2_en,
   input  logic [4:0]  rd2_addr,
   output logic [31:0] rd2_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // Register 0 has no storage; the array starts at index 1.
   logic [31:0] regs [1:31];
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   // A write to index 0 is discarded here, so it cannot create storage.
   logic gpr_we;
   assign gpr_we = wb_en && (wb_addr != 5'd0);

   // ------------------------------------------------------------------
   // GPR storage
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (gpr_we) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // ------------------------------------------------------------------
   // HI/LO storage
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (wb_hilo_en) begin
         hi_r <= wb_hi;
         lo_r <= wb_lo;
      end
   end

   // ------------------------------------------------------------------
   // Read port resolution, in priority order:
   //   reset, port disabled, index 0, bypass hit, stored value.
   // Index 0 is tested before the bypass. A write to r0 in the same cycle
   // must never leak onto a read of r0.
   // ------------------------------------------------------------------
   function automatic logic [31:0] resolve_read(
      input logic       en,
      input logic [4:0] addr
   );
      logic [31:0] val;
      val = '0;
      if (reset) begin
         val = '0;
      end else if (!en) begin
         val = '0;
      end else if (addr == 5'd0) begin
         val = '0;
      end else if (BYPASS && wb_en && (wb_addr == addr)) begin
         val = wb_data;
      end else begin
         val = regs[addr];
      end
      return val;
   endfunction

   always_comb begin
      rd1_data = '0;
      rd1_data = resolve_read(rd1_en, rd1_addr);
   end

   always_comb begin
      rd2_data = '0;
      rd2_data = resolve_read(rd2_en, rd2_addr);
   end

   // ------------------------------------------------------------------
   // HI/LO outputs: the bypass presents the pair being written this cycle.
   // ------------------------------------------------------------------
   always_comb begin
      hi = '0;
      lo = '0;
      if (reset) begin
         hi = '0;
         lo = '0;
      end else if (BYPASS && wb_hilo_en) begin
         hi = wb_hi;
         lo = wb_lo;
      end else begin
         hi = hi_r;
         lo = lo_r;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Drives two instances from the same stimulus:
//   dut     BYPASS=1
//   dut_nb  BYPASS=0
// A behavioural model (register array plus HI/LO) predicts all outputs.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_hilo_en;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;
   logic        rd1_en;
   logic [4:0]  rd1_addr;
   logic        rd2_en;
   logic [4:0]  rd2_addr;
   logic [31:0] rd1_data, rd2_data, hi, lo;
   logic [31:0] nb_rd1_data, nb_rd2_data, nb_hi, nb_lo;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   // ------------------------------------------------------------------
   // Clock and DUT instances
   // ------------------------------------------------------------------
   always #5 clk = ~clk;

   wb_regfile #(.BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_hilo_en(wb_hilo_en), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
      .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_data),
      .hi(hi), .lo(lo)
   );

   wb_regfile #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .reset(reset),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_hilo_en(wb_hilo_en), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(nb_rd1_data),
      .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(nb_rd2_data),
      .hi(nb_hi), .lo(nb_lo)
   );

   // ------------------------------------------------------------------
   // Model
   // ------------------------------------------------------------------
   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_hi = '0;
      m_lo = '0;
   endtask

   // Predict a read port from the architectural rules.
   function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a, input bit byp);
      if (reset || !en || a == 5'd0) return 32'h0;
      if (byp && wb_en && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] exp_hi(input bit byp);
      if (reset) return 32'h0;
      return (byp && wb_hilo_en) ? wb_hi : m_hi;
   endfunction

   function automatic logic [31:0] exp_lo(input bit byp);
      if (reset) return 32'h0;
      return (byp && wb_hilo_en) ? wb_lo : m_lo;
   endfunction

   // One rising edge. The model commits the writes seen at that edge.
   // Control returns 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
         if (wb_hilo_en) begin
            m_hi = wb_hi;
            m_lo = wb_lo;
         end
      end
      #1;
   endtask

   task automatic idle();
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      wb_hilo_en = 1'b0; wb_hi = '0; wb_lo = '0;
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      idle();
      rd1_en = 1'b1; rd1_addr = 5'd5;
      rd2_en = 1'b1; rd2_addr = 5'd31;
      model_clear();
      tick();
      // Write attempts while reset is held must be ignored.
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = $urandom;
      wb_hilo_en = 1'b1; wb_hi = $urandom; wb_lo = $urandom;
      tick();
      #2;
      n_vec++;
      if (rd1_data !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_err++;
         $display("FAIL reset_held: rd1=%h hi=%h lo=%h want 0", rd1_data, hi, lo);
      end
      tick();
      reset = 1'b0;
      idle();
      #2;
      n_vec++;
      if (rd1_data !== 32'h0 || rd2_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rd: rd1=%h rd2=%h want 0", rd1_data, rd2_data);
      end
      n_vec++;
      if (hi !== 32'h0 || lo !== 32'h0 || nb_hi !== 32'h0 || nb_rd1_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_hilo: hi=%h lo=%h nb_hi=%h nb_rd1=%h want 0", hi, lo, nb_hi, nb_rd1_data);
      end
   endtask

   task automatic test_write_readback();
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
      rd1_en = 1'b1; rd1_addr = 5'd7;
      tick();
      idle();
      #2;
      n_vec++;
      if (rd1_data !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL readback: rd1=%h want deadbeef", rd1_data);
      end
      n_vec++;
      if (nb_rd1_data !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL readback_nb: rd1=%h want deadbeef", nb_rd1_data);
      end
      rd1_en = 1'b0;
      #1;
      n_vec++;
      if (rd1_data !== 32'h0) begin
         n_err++;
         $display("FAIL rd_disabled: rd1=%h want 0", rd1_data);
      end
      tick();
   endtask

   task automatic test_reg0();
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      rd1_en = 1'b1; rd1_addr = 5'd0;
      rd2_en = 1'b1; rd2_addr = 5'd0;
      #2;
      n_vec++;
      if (rd1_data !== 32'h0 || rd2_data !== 32'h0) begin
         n_err++;
         $display("FAIL r0_same_cycle: rd1=%h rd2=%h want 0", rd1_data, rd2_data);
      end
      tick();
      idle();
      #2;
      n_vec++;
      if (rd1_data !== 32'h0 || rd2_data !== 32'h0) begin
         n_err++;
         $display("FAIL r0_after_edge: rd1=%h rd2=%h want 0", rd1_data, rd2_data);
      end
      tick();
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
      tick();
      wb_data = 32'h22;
      rd1_en = 1'b1; rd1_addr = 5'd3;
      rd2_en = 1'b1; rd2_addr = 5'd3;
      #2;
      n_vec++;
      if (rd1_data !== 32'h22 || rd2_data !== 32'h22) begin
         n_err++;
         $display("FAIL bypass: rd1=%h rd2=%h want 22", rd1_data, rd2_data);
      end
      n_vec++;
      if (nb_rd1_data !== 32'h11 || nb_rd2_data !== 32'h11) begin
         n_err++;
         $display("FAIL no_bypass_before: rd1=%h rd2=%h want 11", nb_rd1_data, nb_rd2_data);
      end
      tick();
      idle();
      #2;
      n_vec++;
      if (nb_rd1_data !== 32'h22 || nb_rd2_data !== 32'h22) begin
         n_err++;
         $display("FAIL no_bypass_after: rd1=%h rd2=%h want 22", nb_rd1_data, nb_rd2_data);
      end
      tick();
   endtask

   task automatic test_hilo();
      logic [31:0] d9;
      logic [31:0] old_hi;
      d9 = $urandom;
      old_hi = m_hi;
      wb_hilo_en = 1'b1; wb_hi = 32'hA5A5A5A5; wb_lo = 32'h5A5A5A5A;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = d9;
      #2;
      n_vec++;
      if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) begin
         n_err++;
         $display("FAIL hilo_bypass: hi=%h lo=%h want a5a5a5a5/5a5a5a5a", hi, lo);
      end
      n_vec++;
      if (nb_hi !== old_hi) begin
         n_err++;
         $display("FAIL hilo_no_bypass: hi=%h want %h", nb_hi, old_hi);
      end
      tick();
      idle();
      rd1_en = 1'b1; rd1_addr = 5'd9;
      #2;
      n_vec++;
      if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A || nb_lo !== 32'h5A5A5A5A) begin
         n_err++;
         $display("FAIL hilo_hold: hi=%h lo=%h nb_lo=%h", hi, lo, nb_lo);
      end
      n_vec++;
      if (rd1_data !== d9) begin
         n_err++;
         $display("FAIL hilo_gpr9: rd1=%h want %h", rd1_data, d9);
      end
      tick();
   endtask

   task automatic test_async_reset();
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1234;
      wb_hilo_en = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
      tick();
      idle();
      rd1_en = 1'b1; rd1_addr = 5'd4;
      #2;
      n_vec++;
      if (rd1_data !== 32'h1234 || hi !== 32'h1) begin
         n_err++;
         $display("FAIL pre_async: rd1=%h hi=%h want 1234/1", rd1_data, hi);
      end
      // Pulse reset between clock edges.
      reset = 1'b1;
      model_clear();
      #1;
      n_vec++;
      if (rd1_data !== 32'h0 || hi !== 32'h0) begin
         n_err++;
         $display("FAIL async_assert: rd1=%h hi=%h want 0", rd1_data, hi);
      end
      reset = 1'b0;
      #2;
      n_vec++;
      if (rd1_data !== 32'h0 || hi !== 32'h0 || lo !== 32'h0 || nb_rd1_data !== 32'h0) begin
         n_err++;
         $display("FAIL async_release: rd1=%h hi=%h lo=%h nb_rd1=%h want 0", rd1_data, hi, lo, nb_rd1_data);
      end
      tick();
      #2;
      n_vec++;
      if (rd1_data !== 32'h0 || hi !== 32'h0) begin
         n_err++;
         $display("FAIL async_after_edge: rd1=%h hi=%h want 0", rd1_data, hi);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 400; it++) begin
         reset      = ($urandom_range(0, 49) == 0);
         if (reset) model_clear();
         wb_en      = $urandom_range(0, 1);
         wb_addr    = $urandom_range(0, 31);
         wb_data    = $urandom;
         wb_hilo_en = ($urandom_range(0, 3) == 0);
         wb_hi      = $urandom;
         wb_lo      = $urandom;
         rd1_en     = ($urandom_range(0, 7) != 0);
         rd2_en     = ($urandom_range(0, 7) != 0);
         // Bias read addresses toward the write address to hit the bypass.
         rd1_addr   = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom_range(0, 31));
         rd2_addr   = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom_range(0, 31));
         #2;
         n_vec++;
         if (rd1_data !== exp_rd(rd1_en, rd1_addr, 1'b1) || rd2_data !== exp_rd(rd2_en, rd2_addr, 1'b1)) begin
            n_err++;
            $display("FAIL rand_rd it=%0d: rd1=%h/%h rd2=%h/%h", it,
                     rd1_data, exp_rd(rd1_en, rd1_addr, 1'b1), rd2_data, exp_rd(rd2_en, rd2_addr, 1'b1));
         end
         n_vec++;
         if (nb_rd1_data !== exp_rd(rd1_en, rd1_addr, 1'b0) || nb_rd2_data !== exp_rd(rd2_en, rd2_addr, 1'b0)) begin
            n_err++;
            $display("FAIL rand_rd_nb it=%0d: rd1=%h/%h rd2=%h/%h", it,
                     nb_rd1_data, exp_rd(rd1_en, rd1_addr, 1'b0), nb_rd2_data, exp_rd(rd2_en, rd2_addr, 1'b0));
         end
         n_vec++;
         if (hi !== exp_hi(1'b1) || lo !== exp_lo(1'b1) || nb_hi !== exp_hi(1'b0) || nb_lo !== exp_lo(1'b0)) begin
            n_err++;
            $display("FAIL rand_hilo it=%0d: hi=%h/%h lo=%h/%h nb_hi=%h/%h nb_lo=%h/%h", it,
                     hi, exp_hi(1'b1), lo, exp_lo(1'b1), nb_hi, exp_hi(1'b0), nb_lo, exp_lo(1'b0));
         end
         tick();
      end
      reset = 1'b0;
      idle();
   endtask

   // ------------------------------------------------------------------
   // Sequence and report
   // ------------------------------------------------------------------
   initial begin
      reset = 1'b1;
      idle();
      rd1_en = 1'b0; rd1_addr = '0;
      rd2_en = 1'b0; rd2_addr = '0;
      model_clear();
      test_reset();
      test_write_readback();
      test_reg0();
      test_bypass();
      test_hilo();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the pipeline. Consumes the MEM/WB pipeline register outputs (destination address, write enable, write data, HI/LO enable and values), commits them to the 31-entry general register file and the HI/LO register pair, and serves two combinational read ports to the decode stage. Same-cycle write-to-read bypass is built in, so decode never needs a separate WB forwarding path.

## Interface
Parameters:
- BYPASS, default 1: 1 enables the write-to-read bypass on both GPR read ports and on HI/LO; 0 returns stored values only.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_en  in  1  GPR write enable, driven from the MEM/WB register
- wb_addr  in  5  GPR destination index
- wb_data  in  32  GPR write data
- wb_hilo_en  in  1  HI/LO write enable
- wb_hi  in  32  HI write data
- wb_lo  in  32  LO write data
- rd1_en  in  1  read port 1 enable
- rd1_addr  in  5  read port 1 index
- rd1_data  out  32  read port 1 data, combinational
- rd2_en  in  1  read port 2 enable
- rd2_addr  in  5  read port 2 index
- rd2_data  out  32  read port 2 data, combinational
- hi  out  32  current HI, combinational
- lo  out  32  current LO, combinational

## Operation
- Storage: regs[1..31] × 32 bit, plus hi_r and lo_r. Register 0 has no storage and always reads 0.
- Reset (reset=1, asynchronous): regs[1..31], hi_r and lo_r clear to 0 immediately. While reset is high, writes are ignored and rd1_data, rd2_data, hi and lo all read 0.
- GPR write: on the clk rising edge with reset=0, wb_en=1 and wb_addr≠0, regs[wb_addr] ← wb_data. A write to index 0 is discarded.
- HI/LO write: on the clk rising edge with reset=0 and wb_hilo_en=1, hi_r ← wb_hi and lo_r ← wb_lo. The two are always written together. GPR and HI/LO writes are independent and may occur in the same cycle.
- Read port n, evaluated in priority order:
  1. reset=1 → 0
  2. rdn_en=0 → 0
  3. rdn_addr=0 → 0
  4. BYPASS=1, wb_en=1 and wb_addr==rdn_addr → wb_data
  5. otherwise → regs[rdn_addr]
- Both ports may address the same register, and both may hit the bypass at the same time. Each port resolves independently.
- hi/lo: reset=1 → 0. Else, if BYPASS=1 and wb_hilo_en=1 → wb_hi/wb_lo. Else → hi_r/lo_r.
- There is no stall input. Stall and flush are handled upstream: the MEM/WB register inserts bubbles with wb_en=0 and wb_hilo_en=0, or holds its outputs. A held valid write is simply re-written each cycle with the same value, which is harmless.

## Timing
- Write latency: 1 cycle. The value is visible from the stored array starting the cycle after the edge.
- Bypass latency: 0 cycles. Read outputs follow the wb_* inputs combinationally within the same cycle.
- Read path: purely combinational from rdn_en, rdn_addr, wb_en, wb_addr, wb_data and reset. There is no register on the outputs.
- Reset assertion mid-cycle clears state without waiting for clk. After deassertion, the first write takes effect at the first subsequent rising edge.
- Reset values: rd1_data=0, rd2_data=0, hi=0, lo=0, all storage 0.

## Test plan
- Reset then read: assert reset, write attempts ignored; deassert; rd1_addr=5, rd2_addr=31, both enabled → rd1_data=0, rd2_data=0, hi=0, lo=0.
- Write/readback: wb_en=1, wb_addr=7, wb_data=0xDEADBEEF for one edge, then wb_en=0; rd1_addr=7 → 0xDEADBEEF next cycle. With rd1_en=0 → 0.
- Register 0: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, then read addr 0 on both ports → 0 in the same cycle (no bypass) and after the edge.
- Bypass: regs[3]=0x11, then drive wb_en=1, wb_addr=3, wb_data=0x22 with rd1_addr=rd2_addr=3 → both 0x22 before the edge. With BYPASS=0 → both 0x11 before the edge and 0x22 after.
- HI/LO: wb_hilo_en=1, wb_hi=0xA5A5A5A5, wb_lo=0x5A5A5A5A → hi/lo show these values in the same cycle (bypass) and hold them after wb_hilo_en=0. A simultaneous GPR write to reg 9 also lands.
- Async reset mid-operation: regs[4]=0x1234 and hi=0x1, pulse reset between clock edges → rd1_data(addr 4)=0 and hi=0 immediately, still 0 after release with no writes.
